// File: rtl/lr35902_dma.sv
// OAM DMA engine behind register FF46: copies BYTES bytes from {src,00} into OAM,
// one byte per M-cycle (4 T-cycles), acting as initiator of the DMA bus.
module lr35902_dma #(
  parameter int BYTES       = 160,
  parameter int START_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        read,
  input  logic        write,
  output logic        active,
  output logic [15:0] adr_src,
  output logic        rd_src,
  input  logic [7:0]  data_src,
  output logic [7:0]  adr_oam,
  output logic [7:0]  data_oam,
  output logic        wr_oam
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX  = 8'(BYTES - 1);
  localparam logic [7:0] DELAY_LD  = 8'(START_DELAY - 1);

  state_t      state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  ph_q, ph_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  src_eff;

  // The register value is always readable; the top qualifies the read itself.
  logic unused_read;
  assign unused_read = read;

  // NOTE: synchronous reset lives inside the clocked block; every flop here is
  // reset, including data_q, because it is architecturally visible on data_oam.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= 8'h00;
      idx_q    <= 8'h00;
      ph_q     <= 2'd0;
      cnt_q    <= 8'h00;
      active_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      data_q   <= data_d;
    end
  end

  // NOTE: every signal gets a default hold value first, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    data_d   = data_q;
    if (write) begin
      // A write restarts from any state; active is held so a restart never drops it.
      src_d   = din;
      idx_d   = 8'h00;
      ph_d    = 2'd0;
      cnt_d   = DELAY_LD;
      state_d = ST_DELAY;
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (cnt_q == 8'h00) begin
            state_d  = ST_XFER;
            active_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'h01;
          end
        end
        ST_XFER: begin
          if (ph_q == 2'd2) data_d = data_src;
          if (ph_q == 2'd3) begin
            ph_d = 2'd0;
            if (idx_q == LAST_IDX) begin
              state_d  = ST_IDLE;
              active_d = 1'b0;
              idx_d    = 8'h00;
            end else begin
              idx_d = idx_q + 8'h01;
            end
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses 0xE0..0xFF are the echo of work RAM and fold back onto 0xC0..0xDF.
  assign src_eff = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;

  always_comb begin
    rd_src  = 1'b0;
    wr_oam  = 1'b0;
    adr_oam = 8'h00;
    adr_src = {src_eff, 8'h00};
    if (state_q == ST_XFER) begin
      rd_src  = (ph_q != 2'd3);
      // A write landing on the commit phase abandons the byte being written.
      wr_oam  = (ph_q == 2'd3) && !write;
      adr_oam = idx_q;
      adr_src = {src_eff, idx_q};
    end
  end

  assign dout     = src_q;
  assign active   = active_q;
  assign data_oam = data_q;

endmodule

// File: tb/tb_lr35902_dma.sv
// Self-checking bench for lr35902_dma: a bus memory model feeds data_src and a
// transfer-level reference model predicts every OAM write pulse and active edge.
module tb_lr35902_dma;

  localparam int BYTES = 160;
  localparam int DLY   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        read;
  logic        write;
  logic        active;
  logic [15:0] adr_src;
  logic        rd_src;
  logic [7:0]  data_src;
  logic [7:0]  adr_oam;
  logic [7:0]  data_oam;
  logic        wr_oam;

  lr35902_dma #(.BYTES(BYTES), .START_DELAY(DLY)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .read(read),
    .write(write), .active(active), .adr_src(adr_src), .rd_src(rd_src),
    .data_src(data_src), .adr_oam(adr_oam), .data_oam(data_oam), .wr_oam(wr_oam)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign data_src = mem[adr_src];

  typedef struct {
    int          t;
    logic [7:0]  adr;
    logic [7:0]  dat;
    logic [15:0] asrc;
  } pulse_t;

  pulse_t obs_q[$];
  pulse_t exp_q[$];
  int     rise_q[$];
  int     fall_q[$];
  int     cyc = 0;
  int     act_cnt = 0;
  int     rd_cnt = 0;
  int     first_rd = -1;
  logic   act_prev = 1'b0;
  int     tests = 0;
  int     fails = 0;

  // cyc == n during the clock that follows rising edge n.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_oam) obs_q.push_back('{cyc, adr_oam, data_oam, adr_src});
    if (rd_src) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (active) act_cnt++;
    if (active && !act_prev) rise_q.push_back(cyc);
    if (!active && act_prev) fall_q.push_back(cyc);
    act_prev = active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    rise_q.delete();
    fall_q.delete();
    act_cnt  = 0;
    rd_cnt   = 0;
    first_rd = -1;
  endtask

  // Caller is at a negedge; returns the rising edge that samples the write.
  task automatic do_write(input logic [7:0] v, output int e);
    e     = cyc + 1;
    din   = v;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Reference: byte i of a transfer sampled at edge e0 is committed in the
  // clock after edge e0+DLY+3+4*i, reading the echo-folded source page.
  task automatic add_xfer(input logic [7:0] s, input int e0, input int n);
    int eff;
    eff = (s >= 8'hE0) ? int'(s) - 32 : int'(s);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{e0 + DLY + 3 + 4 * i, 8'(i), mem[eff * 256 + i], 16'(eff * 256 + i)});
  endtask

  task automatic compare_pulses(input string tag);
    int n;
    check({tag, " pulse_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s t[%0d]", tag, i), obs_q[i].t, exp_q[i].t);
      check($sformatf("%s adr_oam[%0d]", tag, i), 32'(obs_q[i].adr), 32'(exp_q[i].adr));
      check($sformatf("%s data_oam[%0d]", tag, i), 32'(obs_q[i].dat), 32'(exp_q[i].dat));
      check($sformatf("%s adr_src[%0d]", tag, i), 32'(obs_q[i].asrc), 32'(exp_q[i].asrc));
    end
  endtask

  initial begin
    int e0;
    int e1;
    int n;
    logic [7:0] s;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

    reset = 1'b1; write = 1'b0; read = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst active", 32'(active), 0);
    check("rst rd_src", 32'(rd_src), 0);
    check("rst wr_oam", 32'(wr_oam), 0);
    check("rst adr_src", 32'(adr_src), 0);
    check("rst adr_oam", 32'(adr_oam), 0);
    check("rst data_oam", 32'(data_oam), 0);
    check("rst dout", 32'(dout), 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain transfer from C1.
    clear_obs();
    do_write(8'hC1, e0);
    add_xfer(8'hC1, e0, BYTES);
    wait_until(e0 + DLY + 4 * BYTES + 4);
    compare_pulses("c1");
    check("c1 rise count", rise_q.size(), 1);
    check("c1 fall count", fall_q.size(), 1);
    if (rise_q.size() > 0) check("c1 rise", rise_q[0], e0 + DLY);
    if (fall_q.size() > 0) check("c1 fall", fall_q[0], e0 + DLY + 4 * BYTES);
    check("c1 active clocks", act_cnt, 4 * BYTES);
    check("c1 first rd", first_rd, e0 + DLY);
    check("c1 rd clocks", rd_cnt, 3 * BYTES);
    check("c1 idle adr_src", 32'(adr_src), 32'h0000C100);

    // Echo page E3 folds to C3.
    clear_obs();
    do_write(8'hE3, e0);
    check("e3 dout", 32'(dout), 32'hE3);
    add_xfer(8'hE3, e0, BYTES);
    wait_until(e0 + DLY + 4 * BYTES + 4);
    compare_pulses("e3");
    check("e3 dout after", 32'(dout), 32'hE3);

    // Restart at byte 50, phase 1.
    clear_obs();
    do_write(8'h80, e0);
    wait_until(e0 + DLY + 4 * 50 + 1);
    do_write(8'h90, e1);
    add_xfer(8'h80, e0, 50);
    add_xfer(8'h90, e1, BYTES);
    wait_until(e1 + DLY + 4 * BYTES + 4);
    compare_pulses("restart");
    check("restart rise count", rise_q.size(), 1);
    check("restart fall count", fall_q.size(), 1);
    if (fall_q.size() > 0) check("restart fall", fall_q[0], e1 + DLY + 4 * BYTES);
    check("restart active clocks", act_cnt, e1 + DLY + 4 * BYTES - (e0 + DLY));

    // Reset during byte 20.
    clear_obs();
    s = 8'($urandom_range(0, 255));
    do_write(s, e0);
    wait_until(e0 + DLY + 4 * 20 + 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst mid active", 32'(active), 0);
    check("rst mid wr_oam", 32'(wr_oam), 0);
    check("rst mid rd_src", 32'(rd_src), 0);
    check("rst mid dout", 32'(dout), 0);
    reset = 1'b0;
    add_xfer(s, e0, 20);
    wait_until(e0 + DLY + 4 * BYTES + 20);
    compare_pulses("rst mid");
    check("rst mid rise count", rise_q.size(), 1);
    if (fall_q.size() > 0) check("rst mid fall", fall_q[0], e0 + DLY + 4 * 20 + 2);

    // Write and reset in the same clock: reset wins.
    clear_obs();
    din = 8'($urandom_range(1, 255));
    write = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    write = 1'b0;
    reset = 1'b0;
    check("wr+rst dout", 32'(dout), 0);
    check("wr+rst active", 32'(active), 0);
    repeat (20) @(negedge clk);
    check("wr+rst pulses", obs_q.size(), 0);
    check("wr+rst rises", rise_q.size(), 0);
    check("wr+rst rd", rd_cnt, 0);

    // Back-to-back: second write in the first clock after active falls.
    clear_obs();
    do_write(8'hD0, e0);
    n = 0;
    while (!active && n < 1000) begin @(negedge clk); n++; end
    while (active && n < 1000) begin @(negedge clk); n++; end
    check("b2b wait bound", 32'(n < 1000), 1);
    check("b2b fall", cyc, e0 + DLY + 4 * BYTES);
    do_write(8'hD1, e1);
    add_xfer(8'hD0, e0, BYTES);
    add_xfer(8'hD1, e1, BYTES);
    wait_until(e1 + DLY + 4 * BYTES + 4);
    compare_pulses("b2b");
    check("b2b rise count", rise_q.size(), 2);
    if (rise_q.size() > 1) begin
      check("b2b second rise", rise_q[1], e1 + DLY);
      check("b2b gap", rise_q[1] - fall_q[0], (e1 - (e0 + DLY + 4 * BYTES)) + DLY);
    end
    check("b2b dout", 32'(dout), 32'hD1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
